// File: rtl/my_coin_pkg.sv
// Shared definitions for the coin acceptor.
// Holds the coin code enumeration and the default parameter values used by
// my_coin_fsm and coin_value_decode.
package my_coin_pkg;

  typedef enum logic [1:0] {
    COIN_NONE     = 2'b00,
    COIN_CIRCLE   = 2'b01,
    COIN_TRIANGLE = 2'b10,
    COIN_PENTAGON = 2'b11
  } coin_e;

  localparam int CIRCLE_VAL_DEF   = 1;
  localparam int TRIANGLE_VAL_DEF = 3;
  localparam int PENTAGON_VAL_DEF = 5;
  localparam int GAME_COST_DEF    = 4;
  localparam int CREDIT_W_DEF     = 4;

endpackage

// File: rtl/my_coin_fsm_decode.sv
// coin_value_decode: combinational coin code to credit value mapping.
// Ports:
//   coin_value    [1:0]        coin code (00 none, 01 circle, 10 triangle, 11 pentagon)
//   coin_inserted              qualifies coin_value for this cycle
//   coin_val      [VAL_W-1:0]  credit value of the coin, 0 when no coin
module coin_value_decode
  import my_coin_pkg::*;
#(
  parameter int CIRCLE_VAL   = CIRCLE_VAL_DEF,
  parameter int TRIANGLE_VAL = TRIANGLE_VAL_DEF,
  parameter int PENTAGON_VAL = PENTAGON_VAL_DEF,
  parameter int VAL_W        = CREDIT_W_DEF + 1
) (
  input  logic [1:0]       coin_value,
  input  logic             coin_inserted,
  output logic [VAL_W-1:0] coin_val
);

  always_comb begin
    coin_val = '0;
    if (coin_inserted) begin
      case (coin_e'(coin_value))
        COIN_CIRCLE:   coin_val = VAL_W'(CIRCLE_VAL);
        COIN_TRIANGLE: coin_val = VAL_W'(TRIANGLE_VAL);
        COIN_PENTAGON: coin_val = VAL_W'(PENTAGON_VAL);
        default:       coin_val = '0;  // code 00 with a coin strobe is ignored
      endcase
    end
  end

endmodule

// File: rtl/my_coin_fsm.sv
// my_coin_fsm: coin acceptor front end for the Zorgian Mastermind game.
// Accumulates coin values into a saturating credit register and pulses Drop
// for one cycle per game bought (GAME_COST credits each). No change is given;
// leftover credit carries over.
// Ports:
//   clock                       rising-edge clock
//   reset_n                     synchronous active-low reset
//   CoinValue    [1:0]          coin code
//   CoinInserted                one coin per cycle sampled high
//   Drop                        registered, one cycle high per game
//   Credit       [CREDIT_W-1:0] credit register (only with COIN_FSM_DEBUG_EN)
// Build option: define COIN_FSM_DEBUG_EN to expose Credit and enable the
// credit/Drop consistency assertions.
module my_coin_fsm
  import my_coin_pkg::*;
#(
  parameter int CIRCLE_VAL   = CIRCLE_VAL_DEF,
  parameter int TRIANGLE_VAL = TRIANGLE_VAL_DEF,
  parameter int PENTAGON_VAL = PENTAGON_VAL_DEF,
  parameter int GAME_COST    = GAME_COST_DEF,
  parameter int CREDIT_W     = CREDIT_W_DEF
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [1:0]          CoinValue,
  input  logic                CoinInserted,
`ifdef COIN_FSM_DEBUG_EN
  output logic [CREDIT_W-1:0] Credit,
`endif
  output logic                Drop
);

  // One extra bit so credit + coin can never overflow.
  localparam int SUM_W = CREDIT_W + 1;
  localparam logic [SUM_W-1:0] CREDIT_MAX = SUM_W'((1 << CREDIT_W) - 1);
  localparam logic [SUM_W-1:0] COST       = SUM_W'(GAME_COST);

  logic [CREDIT_W-1:0] credit;
  logic [CREDIT_W-1:0] credit_next;
  logic                drop_next;
  logic [SUM_W-1:0]    coin_val;
  logic [SUM_W-1:0]    sum;

  function automatic logic [CREDIT_W-1:0] sat_credit(input logic [SUM_W-1:0] v);
    logic [SUM_W-1:0] c;
    c = (v > CREDIT_MAX) ? CREDIT_MAX : v;
    return c[CREDIT_W-1:0];
  endfunction

  coin_value_decode #(
    .CIRCLE_VAL   (CIRCLE_VAL),
    .TRIANGLE_VAL (TRIANGLE_VAL),
    .PENTAGON_VAL (PENTAGON_VAL),
    .VAL_W        (SUM_W)
  ) u_decode (
    .coin_value    (CoinValue),
    .coin_inserted (CoinInserted),
    .coin_val      (coin_val)
  );

  // A coin arriving while a game is still owed is folded into the same
  // update as the deduction, so nothing is lost.
  always_comb begin
    sum         = {1'b0, credit} + coin_val;
    drop_next   = 1'b0;
    credit_next = sat_credit(sum);
    if (sum >= COST) begin
      drop_next   = 1'b1;
      credit_next = sat_credit(sum - COST);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      credit <= '0;
      Drop   <= 1'b0;
    end else begin
      credit <= credit_next;
      Drop   <= drop_next;
    end
  end

`ifdef COIN_FSM_DEBUG_EN
  assign Credit = credit;

  a_credit_range: assert property (@(posedge clock) {1'b0, credit} <= CREDIT_MAX);
  a_drop_legal:   assert property (@(posedge clock) disable iff (!reset_n)
                                   Drop |-> ($past(sum) >= COST));
`endif

endmodule

// File: tb/tb_my_coin_fsm.sv
// Testbench for my_coin_fsm: directed coin vectors with hand-computed Drop
// values feed a queue; an independent monitor pops and compares after each
// rising edge.
module tb_my_coin_fsm;

  logic       clock;
  logic       reset_n;
  logic [1:0] CoinValue;
  logic       CoinInserted;
  logic       Drop;

  typedef struct {
    logic       rn;
    logic       ins;
    logic [1:0] val;
    logic       exp;
  } vec_t;

  typedef struct {
    int   idx;
    logic exp;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  my_coin_fsm dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .CoinValue    (CoinValue),
    .CoinInserted (CoinInserted),
    .Drop         (Drop)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic add(input logic rn, input logic ins, input logic [1:0] val,
                     input logic exp, input int n);
    for (int i = 0; i < n; i++) vecs.push_back('{rn, ins, val, exp});
  endtask

  // Monitor: compare Drop one delta-safe step after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (Drop !== e.exp) begin
          errors++;
          $display("FAIL drop[vec %0d]: got %0b expected %0b", e.idx, Drop, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n      = 1'b0;
    CoinInserted = 1'b0;
    CoinValue    = 2'b00;

    // Reset held while pentagons are offered: no credit, no Drop.
    add(0, 1, 2'b11, 0, 3);
    // Five circles: Drop after the 4th, credit ends at 1.
    add(1, 1, 2'b01, 0, 3);
    add(1, 1, 2'b01, 1, 1);
    add(1, 1, 2'b01, 0, 1);
    add(1, 0, 2'b11, 0, 1);              // unqualified code ignored, credit 1
    add(1, 1, 2'b10, 1, 1);              // 1+3 -> Drop, credit 0
    add(1, 0, 2'b00, 0, 1);
    add(1, 1, 2'b11, 1, 1);              // 0+5 -> Drop, credit 1
    add(1, 0, 2'b00, 0, 1);
    add(1, 1, 2'b10, 1, 1);              // 1+3 -> Drop, credit 0
    // Triangle then pentagon: 8 credits, two consecutive drops.
    add(1, 1, 2'b10, 0, 1);              // credit 3
    add(1, 1, 2'b11, 1, 1);              // credit 4
    add(1, 0, 2'b00, 1, 1);              // credit 0
    add(1, 0, 2'b00, 0, 1);
    // Circle during pending second drop: 4+1-4 = 1, then triangle makes 4.
    add(1, 1, 2'b10, 0, 1);              // credit 3
    add(1, 1, 2'b11, 1, 1);              // credit 4
    add(1, 1, 2'b01, 1, 1);              // credit 1
    add(1, 0, 2'b00, 0, 1);
    add(1, 1, 2'b10, 1, 1);              // credit 0
    add(1, 0, 2'b00, 0, 1);
    // Code 00 with strobe adds nothing: four circles then needed for a game.
    add(1, 1, 2'b00, 0, 3);
    add(1, 1, 2'b01, 0, 3);
    add(1, 1, 2'b01, 1, 1);              // credit 0
    add(1, 0, 2'b00, 0, 1);
    // Pentagon every cycle: credit climbs +1 per cycle and pins at 15.
    add(1, 1, 2'b11, 1, 20);
    // Drain 15: 11, 7, 3, then no drop.
    add(1, 0, 2'b00, 1, 3);
    add(1, 0, 2'b00, 0, 1);
    add(1, 1, 2'b01, 1, 1);              // 3+1 -> credit 0 proves clamp at 15
    add(1, 0, 2'b00, 0, 1);
    // Reset discards pending credit even with a coin present.
    add(1, 1, 2'b10, 0, 1);              // credit 3
    add(0, 1, 2'b11, 0, 1);              // credit 0
    add(1, 1, 2'b01, 0, 3);              // credit 1,2,3
    add(1, 1, 2'b01, 1, 1);              // credit 0
    add(1, 0, 2'b00, 0, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      reset_n      = vecs[i].rn;
      CoinInserted = vecs[i].ins;
      CoinValue    = vecs[i].val;
      exp_q.push_back('{i, vecs[i].exp});
    end
    @(negedge clock);
    CoinInserted = 1'b0;
    CoinValue    = 2'b00;
    repeat (3) @(negedge clock);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected values left, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
